// File: rtl/read_mem.sv
// read_mem: readout stage for the logic analyzer capture buffer.
//
// When capture stops (start pulse), walks the circular sample memory from the
// oldest valid entry to the newest and streams each sample over valid/ready,
// flagging the final word with o_last. busy stays high for the whole dump so
// the parent can gate the writer and keep memory and write pointer frozen.
//
// Ports:
//   clk         in   sole clock, rising edge
//   reset       in   asynchronous active-low reset
//   start       in   capture-complete pulse, honoured only in IDLE
//   waddr       in   writer's next write location (sampled at start)
//   primed      in   writer has wrapped at least once (sampled at start)
//   raddr       out  registered read address into the buffer
//   rdata       in   buffer word at raddr (combinational read)
//   o_data      out  streamed sample, registered
//   o_valid     out  o_data is valid
//   o_ready     in   consumer accepts o_data
//   o_last      out  final word of the dump
//   busy        out  high from the cycle after start through the done cycle
//   done        out  one-cycle pulse at the end of the dump
//   dbg_state_o out  current FSM state, for observation only
//
// Handshake: a word transfers on any rising edge where o_valid && o_ready.
// Once o_valid rises, o_data/o_last hold until that transfer; o_valid never
// depends combinationally on o_ready.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif

module read_mem #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int ADDR_WIDTH = `ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic                  primed,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic                  o_last,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            dbg_state_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]            state_q,     state_d;
    logic [ADDR_WIDTH-1:0] raddr_q,     raddr_d;
    logic [DATA_WIDTH-1:0] data_q,      data_d;
    logic                  valid_q,     valid_d;
    logic                  last_q,      last_d;
    // One bit wider than the address so a full buffer (2^ADDR_WIDTH) fits.
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic [ADDR_WIDTH:0]   start_count;

    // A primed buffer is full: oldest entry sits at the write pointer.
    // Otherwise the valid entries are 0 .. waddr-1.
    assign start_count = primed ? {1'b1, {ADDR_WIDTH{1'b0}}} : {1'b0, waddr};

    always_comb begin
        state_d     = state_q;
        raddr_d     = raddr_q;
        data_d      = data_q;
        valid_d     = valid_q;
        last_d      = last_q;
        remaining_d = remaining_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    raddr_d     = primed ? waddr : '0;
                    remaining_d = start_count;
                    state_d     = (start_count == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                data_d  = rdata;
                valid_d = 1'b1;
                last_d  = (remaining_q == {{ADDR_WIDTH{1'b0}}, 1'b1});
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (valid_q && o_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        raddr_d     = raddr_q + 1'b1;
                        remaining_d = remaining_q - 1'b1;
                        state_d     = ST_LOAD;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            raddr_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            raddr_q     <= raddr_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            remaining_q <= remaining_d;
        end
    end

    assign raddr       = raddr_q;
    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_last      = last_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_read_mem.sv
// Directed testbench for read_mem with a 16-entry buffer model whose
// location i holds 0xA0+i.
module tb_read_mem;
    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          primed = 1'b0;
    logic          o_ready = 1'b1;
    logic [AW-1:0] waddr = '0;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          o_last;
    logic          busy;
    logic          done;
    logic [1:0]    dbg_state;

    logic [DW-1:0] mem [16];
    logic [DW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rdata = mem[raddr];

    read_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .waddr(waddr), .primed(primed),
        .raddr(raddr), .rdata(rdata), .o_data(o_data), .o_valid(o_valid),
        .o_ready(o_ready), .o_last(o_last), .busy(busy), .done(done),
        .dbg_state_o(dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one dump from a negedge. n words expected starting at buffer
    // address base; done expected in cycle exp_done (cycle 1 follows the
    // edge that samples start). mode 1 drives o_ready as 1,0,0 repeating.
    task automatic run_dump(input int n, input int base, input int exp_done, input int mode,
                            input bit poke_start, input bit change_ptr,
                            input logic [AW-1:0] new_waddr, input logic new_primed);
        int cyc;
        int got;
        int done_cyc;
        bit stalled;
        bit seen_done;
        logic [DW-1:0] held;
        logic [DW-1:0] w;
        exp_q.delete();
        for (int k = 0; k < n; k++) exp_q.push_back(8'hA0 + 8'((base + k) % 16));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        if (change_ptr) begin
            waddr  = new_waddr;
            primed = new_primed;
        end
        check("busy_cycle1", busy, 1);
        if (n > 0) check("raddr_cycle1", raddr, base % 16);
        got = 0;
        done_cyc = -1;
        stalled = 1'b0;
        seen_done = 1'b0;
        held = '0;
        while (cyc <= 100 && !seen_done) begin
            o_ready = (mode == 0) ? 1'b1 : (((cyc - 1) % 3) == 0);
            if (o_valid) begin
                if (stalled) check("stall_hold", o_data, held);
                check("raddr_word", raddr, (base + got) % 16);
                if (o_ready) begin
                    w = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                    check("data", o_data, w);
                    check("last", o_last, (got == n - 1));
                    got++;
                    stalled = 1'b0;
                end else begin
                    held = o_data;
                    stalled = 1'b1;
                end
            end
            if (done) begin
                seen_done = 1'b1;
                done_cyc = cyc;
            end
            start = poke_start && (cyc == 4 || done);
            if (!seen_done) begin
                @(negedge clk);
                cyc++;
            end
        end
        check("word_count", got, n);
        check("done_cycle", done_cyc, exp_done);
        @(negedge clk);
        start = 1'b0;
        o_ready = 1'b1;
        check("busy_after", busy, 0);
        check("done_pulse", done, 0);
        check("valid_after", o_valid, 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_raddr", raddr, 0);
        check("rst_o_data", o_data, 0);
        check("rst_o_valid", o_valid, 0);
        check("rst_o_last", o_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b1;
        @(negedge clk);

        // Unprimed partial dump: 5 words 0xA0..0xA4, done in cycle 11
        primed = 1'b0; waddr = 4'd5;
        run_dump(5, 0, 11, 0, 1'b0, 1'b0, '0, 1'b0);

        // Primed wrapped dump: 0xC..0xF then 0x0..0xB, done in cycle 33
        primed = 1'b1; waddr = 4'hC;
        run_dump(16, 12, 33, 0, 1'b0, 1'b0, '0, 1'b0);

        // Empty dump: done in cycle 1, no words
        primed = 1'b0; waddr = 4'd0;
        run_dump(0, 0, 1, 0, 1'b0, 1'b0, '0, 1'b0);

        // Backpressure 1,0,0: 3 words, done in cycle 11
        primed = 1'b0; waddr = 4'd3;
        run_dump(3, 0, 11, 1, 1'b0, 1'b0, '0, 1'b0);

        // start pulsed during SEND and during DONE is ignored
        primed = 1'b0; waddr = 4'd5;
        run_dump(5, 0, 11, 0, 1'b1, 1'b0, '0, 1'b0);

        // Pointer change after start: latched 7 unprimed words still used
        primed = 1'b0; waddr = 4'd7;
        run_dump(7, 0, 15, 0, 1'b0, 1'b1, 4'd2, 1'b1);
        primed = 1'b0;

        // Mid-dump asynchronous reset, then a fresh replay
        waddr = 4'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_valid", o_valid, 1);
        check("pre_rst_raddr", raddr, 1);
        #2 reset = 1'b0;
        #1;
        check("async_valid", o_valid, 0);
        check("async_busy", busy, 0);
        check("async_raddr", raddr, 0);
        check("async_o_data", o_data, 0);
        check("async_o_last", o_last, 0);
        check("async_done", done, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_dump(5, 0, 11, 0, 1'b0, 1'b0, '0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/read_mem.md
# read_mem

Readout stage for the logic analyzer capture buffer, directly downstream of the buffer writer. When capture stops, it walks the circular sample memory from the oldest valid entry to the newest and streams each sample out over a valid/ready interface, flagging the last word. While it runs, it holds off further writes so the buffer contents and write pointer stay frozen.

## Interface
- `DATA_WIDTH`, default `` `DATA_WIDTH ``: sample width.
- `ADDR_WIDTH`, default `` `ADDR_WIDTH ``: buffer address width; depth = 2^ADDR_WIDTH (= `` `MEMORY_SIZE ``).

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  capture-complete pulse; sampled only in IDLE.
- `waddr`  in  ADDR_WIDTH  writer's current write pointer (next location to be written).
- `primed`  in  1  high once the writer has wrapped at least once, meaning every location holds valid data.
- `raddr`  out  ADDR_WIDTH  read address into the buffer, registered.
- `rdata`  in  DATA_WIDTH  buffer word at `raddr`; combinational read, valid in the same cycle.
- `o_data`  out  DATA_WIDTH  streamed sample, registered.
- `o_valid`  out  1  `o_data` is valid.
- `o_ready`  in  1  consumer accepts `o_data`.
- `o_last`  out  1  qualifies the final word of the dump.
- `busy`  out  1  high from the cycle after `start` until `done`, inclusive; the parent ANDs `write_enable` with `!busy`.
- `done`  out  1  one-cycle pulse at the end of the dump.

## Operation
- States: IDLE, LOAD, SEND, DONE.
- **IDLE**: on `start`, latch the base address and the word count.
  - Base = `primed ? waddr : 0`.
  - Count (ADDR_WIDTH+1 bits) = `primed ? 2^ADDR_WIDTH : waddr`.
  - Load `raddr <= base`.
  - If count == 0, go to DONE; otherwise go to LOAD.
- **LOAD**: `o_data <= rdata`, `o_valid <= 1`, `o_last <= (remaining == 1)`, then go to SEND.
- **SEND**: hold `o_data`, `o_valid` and `o_last` stable until `o_valid && o_ready`. On that handshake:
  - Clear `o_valid`.
  - If `o_last` is set, go to DONE.
  - Otherwise `raddr <= raddr + 1` (modulo 2^ADDR_WIDTH, wraps from all-ones to 0), decrement remaining, and go to LOAD.
- **DONE**: `done = 1` for exactly one cycle, then go to IDLE.
- `busy` = state != IDLE.
- `start` is ignored outside IDLE, including during DONE.
- `waddr` and `primed` are sampled only at `start`. Later changes to either are ignored until the next dump.
- **Reset**: low `reset` forces IDLE immediately (asynchronous), from any state including mid-dump. No resume; the next `start` begins a fresh dump.
- **Output reset values**: `raddr` = 0, `o_data` = 0, `o_valid` = 0, `o_last` = 0, `busy` = 0, `done` = 0.

## Timing
- `start` is sampled at edge E0.
  - `busy` rises and `raddr` = base in cycle 1.
  - `o_valid` first rises in cycle 2.
- Each word costs at least 2 cycles (LOAD + SEND). With `o_ready` held high, words appear every other cycle.
- An N-word dump with `o_ready` constantly high:
  - Last handshake in cycle 2N.
  - `done` in cycle 2N+1.
  - `busy` falls in cycle 2N+2.
- An empty dump (count 0): `done` in cycle 1, `busy` high in cycle 1 only, `o_valid` never asserts.
- Backpressure: each `o_ready` low cycle in SEND adds one cycle. Data never changes while `o_valid` is high and unaccepted.
- `o_valid` never depends combinationally on `o_ready`.

## Test plan
- **Unprimed partial dump** (ADDR_WIDTH=4; memory[i]=0xA0+i; `primed`=0, `waddr`=5; `start`; `o_ready`=1) -> exactly 5 words, 0xA0..0xA4. `o_last` is set only on 0xA4. `done` in cycle 11.
- **Primed wrapped dump** (`primed`=1, `waddr`=0xC) -> 16 words in order from memory[0xC..0xF] then memory[0x0..0xB]. `raddr` wraps 0xF->0x0. `o_last` is set on memory[0xB]. `done` in cycle 33.
- **Empty dump** (`primed`=0, `waddr`=0; `start`) -> no `o_valid`; `done` in cycle 1; `busy` high for exactly 1 cycle.
- **Backpressure**: drive `o_ready` with the pattern 1,0,0,1,... during an unprimed `waddr`=3 dump -> `o_data` stays stable while stalled. All 3 words arrive, none duplicated or dropped.
- **Start during busy and mid-dump reset**: pulse `start` again during SEND -> ignored, no restart. Assert `reset` low mid-dump -> `o_valid`, `busy` and `raddr` go to 0 without waiting for a clock edge. The next `start` replays the dump from the base address.
- **Pointer change after start**: change `waddr` and `primed` after `start` -> the dump length and order follow the values latched at `start`.
